led_counter_ctrl: RTL
=====================

Name: led_counter_ctrl

Overview:
- Parametrised up/down counter for the LED bank; successor to the fixed 8-bit button-increment counter in the top level.
- Supports a step mode (one count per debounced button pulse) and a run mode (one count per prescaler tick), selectable direction, wrap or saturate overflow, and parallel load.
- Sits between the button debouncers and the LED output assignment in the top level; count drives the LEDs directly.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- DIV, 50000000, prescaler period in clk cycles for run mode (>=1; 50 MHz -> 1 Hz).
- PW, $clog2(DIV) (min 1), prescaler register width; derived, not overridden.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous reset, active-high.
- run  in  1  1 = run mode (count on prescaler tick); 0 = step mode.
- dir  in  1  run-mode direction: 1 = up, 0 = down.
- sat  in  1  overflow policy: 1 = saturate, 0 = wrap.
- step_up  in  1  single-cycle pulse from debouncer btn_down; honoured in step mode only.
- step_down  in  1  single-cycle pulse; honoured in step mode only.
- load  in  1  parallel load strobe.
- load_value  in  WIDTH  value loaded on load.
- count  out  WIDTH  current counter value.
- tick  out  1  one-cycle pulse, cycle after each prescaler terminal count.
- wrap_pulse  out  1  one-cycle pulse, cycle after a wrap (max->0 or 0->max).
- at_max  out  1  count == 2^WIDTH-1 (combinational from count register).
- at_min  out  1  count == 0 (combinational from count register).

Behaviour:
- Reset: count=0, prescaler=0, tick=0, wrap_pulse=0; at_min=1, at_max=0. rst dominates all inputs.
- Priority per rising edge: rst > load > count event.
- load: count<=load_value, prescaler<=0, wrap_pulse<=0, tick<=0; pending step/tick events that edge are discarded.
- Prescaler: held at 0 while run=0. While run=1: if prescaler==DIV-1, it goes to 0 and a run event fires that edge; otherwise it increments. First run event occurs on the DIV-th consecutive edge with run=1. DIV=1 produces an event every edge.
- tick: registered copy of run event; high exactly one cycle, coincident with the updated count.
- Run mode event: count +1 if dir=1, -1 if dir=0. step_up/step_down ignored.
- Step mode (run=0): step_up alone -> +1; step_down alone -> -1; both the same edge -> no change, no wrap_pulse.
- Latency: count changes on the edge sampling the event; visible the following cycle.
- Overflow, wrap mode (sat=0): max+1 -> 0, 0-1 -> max; wrap_pulse=1 for the one cycle the new value is visible.
- Overflow, saturate mode (sat=1): +1 at max and -1 at 0 leave count unchanged; wrap_pulse stays 0.
- wrap_pulse is 0 in every cycle not directly following a wrap.
- Mode change mid-operation: run 1->0 clears the prescaler the next edge with no event; sat/dir changes take effect on the next event. No partial state is retained.
- Arithmetic is modulo 2^WIDTH before the saturate check. Overflow is detected from the pre-increment at_max/at_min, not from a carry into an extra bit.

Test Plan (WIDTH=4, DIV=4):
- Reset, then run=1, dir=1, sat=0 held 20 cycles -> tick every 4th cycle; count 0,1,2,3,4,5 after ticks 0..5; no wrap_pulse.
- load_value=14, load, then run up wrap mode -> count 15, then 0 with wrap_pulse=1 for one cycle; at_min=1.
- load 1, run=0, sat=1, three step_down pulses -> count 0,0,0; wrap_pulse never asserts; at_min stays 1. Repeat with load 14 and three step_up pulses -> count 15, 15, 15.
- run=0, step_up and step_down in the same cycle at count 5 -> count stays 5. step_up alone -> 6 next cycle.
- run=1 for 2 cycles, run=0 for 1 cycle, run=1 again -> no tick until 4 consecutive run-high edges; first tick at the 4th.
- Assert rst and load together with load_value=9 mid-run at count 7 -> count=0, tick=0, wrap_pulse=0 next cycle; prescaler restarts a full DIV period.

Source files
------------

// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: LED up/down counter; ports: clk, rst, run, dir, sat, step_up, step_down, load, load_value in; count, tick, wrap_pulse, at_max, at_min out
module led_counter_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV = 50000000,
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dir,
  input  logic             sat,
  input  logic             step_up,
  input  logic             step_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap_pulse,
  output logic             at_max,
  output logic             at_min
);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  logic [PW-1:0] pre;
  logic run_evt, up, dn, evt, ovf;
  assign at_max = &count;
  assign at_min = ~|count;
  always_comb begin
    run_evt = run && pre == PMAX;
    up = run ? dir : step_up && !step_down;
    dn = run ? !dir : step_down && !step_up;
    evt = run ? run_evt : up || dn;
    ovf = (up && at_max) || (dn && at_min);
  end
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= rst ? '0 : load_value;
      pre <= '0;
      tick <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      pre <= run && !run_evt ? pre + 1'b1 : '0;
      tick <= run_evt;
      wrap_pulse <= evt && ovf && !sat;
      if (evt && !(ovf && sat))
        count <= up ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule
